// File: rtl/stream_mux_arb_pkg.sv
// Shared constants and helpers for the stream multiplexer/arbiter slice.
package stream_mux_pkg;

    localparam int MODE_SELECT      = 0;
    localparam int MODE_ROUND_ROBIN = 1;

    // Advance a channel index by one, wrapping back to 0 at n.
    function automatic int next_index(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// Ptr, wrapping around to the channels below Ptr.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    Req,
    input  logic [SELW-1:0] Ptr,
    output logic [N-1:0]    Gnt,
    output logic [SELW-1:0] GntIdx
);

    logic found;

    // Two ordered passes (at/above Ptr, then below Ptr) give the wrapped priority order.
    always_comb begin
        Gnt    = '0;
        GntIdx = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && Req[i] && (i >= int'(Ptr))) begin
                found  = 1'b1;
                Gnt[i] = 1'b1;
                GntIdx = SELW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && Req[i] && (i < int'(Ptr))) begin
                found  = 1'b1;
                Gnt[i] = 1'b1;
                GntIdx = SELW'(i);
            end
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-to-1 stream multiplexer with valid/ready handshakes and a registered
// output stage. Channel choice is either an external index or round-robin.
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N        = 4,
    parameter int SELW     = $clog2(N),
    parameter int ARB_MODE = 0
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic [N-1:0]       InValid,
    output logic [N-1:0]       InReady,
    input  logic [N*WIDTH-1:0] InData,
    input  logic [SELW-1:0]    Select,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [WIDTH-1:0]   OutData,
    output logic [SELW-1:0]    OutChannel
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_channel_q, out_channel_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             load;
    logic [N-1:0]     grant;
    logic [SELW-1:0]  grant_idx;
    logic             transfer;
    logic [WIDTH-1:0] sel_data;

    // The output register can accept a word when empty or draining this cycle.
    assign load = !out_valid_q || OutReady;

    generate
        if (ARB_MODE == MODE_ROUND_ROBIN) begin : g_rr
            logic unused_select;
            assign unused_select = ^Select;

            rr_arbiter #(
                .N    (N),
                .SELW (SELW)
            ) u_rr_arbiter (
                .Req    (InValid),
                .Ptr    (ptr_q),
                .Gnt    (grant),
                .GntIdx (grant_idx)
            );
        end else begin : g_select
            // An out-of-range Select matches no channel, so no grant is issued.
            always_comb begin
                grant = '0;
                for (int i = 0; i < N; i++) begin
                    grant[i] = (Select == SELW'(i)) && InValid[i];
                end
            end
            assign grant_idx = Select;
        end
    endgenerate

    // Ready only reaches the granted channel, and never while in reset.
    assign InReady  = Reset_n ? (grant & {N{load}}) : '0;
    assign transfer = |(InValid & InReady);

    // Route the granted channel's data toward the output register.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = InData[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state: load on transfer, empty on drain-without-refill, else hold.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        ptr_d         = ptr_q;
        if (transfer) begin
            out_valid_d   = 1'b1;
            out_data_d    = sel_data;
            out_channel_d = grant_idx;
            if (ARB_MODE == MODE_ROUND_ROBIN) begin
                ptr_d = SELW'(next_index(int'(grant_idx), N));
            end
        end else if (OutReady) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and round-robin pointer; reset discards any in-flight word.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            ptr_q         <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            ptr_q         <= ptr_d;
        end
    end

    assign OutValid   = out_valid_q;
    assign OutData    = out_data_q;
    assign OutChannel = out_channel_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: a SELECT instance (N=4, widened index),
// a 4-channel round-robin instance and a 3-channel round-robin instance.
module tb_stream_mux_arb;

    logic clock;
    logic reset_n;

    int checkCount;
    int errorCount;

    // SELECT-mode instance, index widened to 3 bits to reach out-of-range values
    logic [3:0]   s_in_valid, s_in_ready;
    logic [127:0] s_in_data;
    logic [2:0]   s_select;
    logic         s_out_valid, s_out_ready;
    logic [31:0]  s_out_data;
    logic [2:0]   s_out_channel;

    // Round-robin, 4 channels
    logic [3:0]   a_in_valid, a_in_ready;
    logic [127:0] a_in_data;
    logic [1:0]   a_select;
    logic         a_out_valid, a_out_ready;
    logic [31:0]  a_out_data;
    logic [1:0]   a_out_channel;

    // Round-robin, 3 channels
    logic [2:0]   b_in_valid, b_in_ready;
    logic [95:0]  b_in_data;
    logic [1:0]   b_select;
    logic         b_out_valid, b_out_ready;
    logic [31:0]  b_out_data;
    logic [1:0]   b_out_channel;

    stream_mux_arb #(.WIDTH(32), .N(4), .SELW(3), .ARB_MODE(0)) dut_sel (
        .Clock(clock), .Reset_n(reset_n),
        .InValid(s_in_valid), .InReady(s_in_ready), .InData(s_in_data),
        .Select(s_select), .OutValid(s_out_valid), .OutReady(s_out_ready),
        .OutData(s_out_data), .OutChannel(s_out_channel)
    );

    stream_mux_arb #(.WIDTH(32), .N(4), .ARB_MODE(1)) dut_rr4 (
        .Clock(clock), .Reset_n(reset_n),
        .InValid(a_in_valid), .InReady(a_in_ready), .InData(a_in_data),
        .Select(a_select), .OutValid(a_out_valid), .OutReady(a_out_ready),
        .OutData(a_out_data), .OutChannel(a_out_channel)
    );

    stream_mux_arb #(.WIDTH(32), .N(3), .ARB_MODE(1)) dut_rr3 (
        .Clock(clock), .Reset_n(reset_n),
        .InValid(b_in_valid), .InReady(b_in_ready), .InData(b_in_data),
        .Select(b_select), .OutValid(b_out_valid), .OutReady(b_out_ready),
        .OutData(b_out_data), .OutChannel(b_out_channel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value against its hand-computed expectation.
    task checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to the falling edge after the given number of rising edges.
    task applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
        end
    endtask

    // Pulse reset low in the middle of the low clock phase.
    task pulseReset;
        @(negedge clock);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        reset_n     = 1'b0;
        s_in_valid  = 4'b1111; s_in_data = '0; s_select = '0; s_out_ready = 1'b0;
        a_in_valid  = 4'b1111; a_in_data = '0; a_select = '0; a_out_ready = 1'b0;
        b_in_valid  = 3'b000;  b_in_data = '0; b_select = '0; b_out_ready = 1'b0;

        // Reset held with all channels requesting
        #12;
        checkOutput("rst_out_valid",   64'(s_out_valid),   64'd0);
        checkOutput("rst_out_data",    64'(s_out_data),    64'd0);
        checkOutput("rst_out_channel", 64'(s_out_channel), 64'd0);
        checkOutput("rst_in_ready",    64'(s_in_ready),    64'h0);
        checkOutput("rst_rr_in_ready", 64'(a_in_ready),    64'h0);
        applyStimulus(1);
        s_in_valid = 4'b0000;
        a_in_valid = 4'b0000;
        reset_n    = 1'b1;

        // SELECT: channel 2 passes through with one cycle latency
        applyStimulus(1);
        s_select = 3'd2;
        s_in_valid = 4'b0100;
        s_in_data[2*32 +: 32] = 32'hDEADBEEF;
        s_out_ready = 1'b1;
        #1;
        checkOutput("sel_in_ready", 64'(s_in_ready), 64'h4);
        applyStimulus(1);
        checkOutput("sel_out_valid",   64'(s_out_valid),   64'd1);
        checkOutput("sel_out_data",    64'(s_out_data),    64'hDEADBEEF);
        checkOutput("sel_out_channel", 64'(s_out_channel), 64'd2);

        // Drain without refill: valid drops, data held
        s_in_valid = 4'b0000;
        applyStimulus(1);
        checkOutput("drain_out_valid", 64'(s_out_valid), 64'd0);
        checkOutput("drain_out_data",  64'(s_out_data),  64'hDEADBEEF);

        // Out-of-range Select grants nothing
        s_select = 3'd5;
        s_in_valid = 4'b1111;
        #1;
        checkOutput("sel_oor_in_ready", 64'(s_in_ready), 64'h0);
        applyStimulus(1);
        checkOutput("sel_oor_out_valid", 64'(s_out_valid), 64'd0);

        // Backpressure: hold 0x11 while channel 1 waits with 0x22
        s_select = 3'd0;
        s_in_valid = 4'b0001;
        s_in_data[0 +: 32] = 32'h11;
        s_out_ready = 1'b1;
        applyStimulus(1);
        checkOutput("bp_load_data", 64'(s_out_data), 64'h11);
        s_select = 3'd1;
        s_in_valid = 4'b0010;
        s_in_data[32 +: 32] = 32'h22;
        s_out_ready = 1'b0;
        #1;
        checkOutput("bp_in_ready_0", 64'(s_in_ready), 64'h0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1);
            checkOutput("bp_hold_data",  64'(s_out_data),  64'h11);
            checkOutput("bp_hold_valid", 64'(s_out_valid), 64'd1);
            checkOutput("bp_hold_ready", 64'(s_in_ready),  64'h0);
        end
        s_out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 64'(s_in_ready), 64'h2);
        applyStimulus(1);
        checkOutput("bp_new_valid",   64'(s_out_valid),   64'd1);
        checkOutput("bp_new_data",    64'(s_out_data),    64'h22);
        checkOutput("bp_new_channel", 64'(s_out_channel), 64'd1);

        // Asynchronous reset with a word held in the output register
        s_in_valid = 4'b0000;
        s_out_ready = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 64'(s_out_valid), 64'd0);
        checkOutput("arst_out_data",  64'(s_out_data),  64'd0);
        applyStimulus(1);
        reset_n = 1'b1;

        // Round-robin rotation with all four channels valid
        a_in_data = {32'd3, 32'd2, 32'd1, 32'd0};
        a_in_valid = 4'b1111;
        a_out_ready = 1'b1;
        #1;
        checkOutput("rr4_first_ready", 64'(a_in_ready), 64'h1);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1);
            checkOutput("rr4_valid",   64'(a_out_valid),   64'd1);
            checkOutput("rr4_channel", 64'(a_out_channel), 64'(k % 4));
            checkOutput("rr4_data",    64'(a_out_data),    64'(k % 4));
        end
        a_in_valid = 4'b0000;
        applyStimulus(1);
        checkOutput("rr4_drain_valid", 64'(a_out_valid), 64'd0);

        // Reset returns the pointer to 0 so channel 0 is favoured again
        pulseReset();
        a_in_valid = 4'b1111;
        #1;
        checkOutput("rr4_post_rst_ready", 64'(a_in_ready), 64'h1);
        applyStimulus(1);
        a_in_valid = 4'b0000;
        checkOutput("rr4_post_rst_channel", 64'(a_out_channel), 64'd0);
        applyStimulus(1);

        // N=3 sparse requests: move pointer to 2, then ch0/ch1 alternate with wrap
        b_in_data = {32'hC2, 32'hC1, 32'hC0};
        b_out_ready = 1'b1;
        b_in_valid = 3'b010;
        applyStimulus(1);
        checkOutput("rr3_setup_channel", 64'(b_out_channel), 64'd1);
        b_in_valid = 3'b011;
        #1;
        checkOutput("rr3_wrap_ready", 64'(b_in_ready), 64'h1);
        applyStimulus(1);
        checkOutput("rr3_order0", 64'(b_out_channel), 64'd0);
        applyStimulus(1);
        checkOutput("rr3_order1", 64'(b_out_channel), 64'd1);
        applyStimulus(1);
        checkOutput("rr3_order2", 64'(b_out_channel), 64'd0);
        checkOutput("rr3_order2_data", 64'(b_out_data), 64'hC0);
        b_in_valid = 3'b000;
        applyStimulus(1);

        // Lone ch2 request from pointer 0 is granted at once; pointer wraps to 0
        pulseReset();
        b_in_valid = 3'b100;
        #1;
        checkOutput("rr3_lone_ready", 64'(b_in_ready), 64'h4);
        applyStimulus(1);
        checkOutput("rr3_lone_channel", 64'(b_out_channel), 64'd2);
        checkOutput("rr3_lone_data",    64'(b_out_data),    64'hC2);
        b_in_valid = 3'b110;
        #1;
        checkOutput("rr3_ptr_wrapped", 64'(b_in_ready), 64'h2);
        applyStimulus(1);
        b_in_valid = 3'b000;
        applyStimulus(2);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
